// File: rtl/io_oserdes_if.sv
// Word-in / serial-out bundle between fabric, io_oserdes and the IO block pins.
// Latency: none (wires only).
// Backpressure: DREADY from the serializer gates DVALID transfers.
interface io_oserdes_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] DIN;
    logic             DVALID;
    logic             DREADY;
    logic             OUT;
    logic             TS;
    logic             BUSY;

    // Fabric side: offers words, observes the pin and status.
    modport master (
        output DIN,
        output DVALID,
        input  DREADY,
        input  OUT,
        input  TS,
        input  BUSY
    );

    // Serializer side: accepts words, drives the pin and status.
    modport slave (
        input  DIN,
        input  DVALID,
        output DREADY,
        output OUT,
        output TS,
        output BUSY
    );
endinterface

// File: rtl/io_oserdes.sv
// Parallel-to-serial pin driver, LSB first, with TS high only while a bit is driven.
// Latency: word accepted at edge N shows bit 0 on OUT/TS in cycle N+1, bit k in cycle N+1+k.
// Backpressure: one-word HOLD buffer; DREADY drops while HOLD is full, giving gapless bursts.
module io_oserdes #(
    parameter int WIDTH = 8
) (
    input  logic        IOCLK,
    input  logic        RST,
    io_oserdes_if.slave s
);
    localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic             out_q, ts_q;
    logic             xfer;

    // DREADY never looks at DVALID, so no combinational loop through fabric.
    assign s.DREADY = !hold_full_q && !RST;
    assign xfer     = s.DVALID && s.DREADY;
    assign s.OUT    = out_q;
    assign s.TS     = ts_q;
    assign s.BUSY   = (state_q == SHIFT);

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bitcnt_d    = bitcnt_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    shreg_d  = s.DIN;
                    bitcnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (bitcnt_q != LAST) begin
                    bitcnt_d = bitcnt_q + CW'(1);
                    if (xfer) begin
                        hold_d      = s.DIN;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    // DREADY is low here, so the held word cannot collide with DIN.
                    shreg_d     = hold_q;
                    hold_full_d = 1'b0;
                    bitcnt_d    = '0;
                end else if (xfer) begin
                    shreg_d  = s.DIN;
                    bitcnt_d = '0;
                end else begin
                    bitcnt_d = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge IOCLK) begin
        if (RST) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bitcnt_q    <= '0;
            out_q       <= 1'b0;
            ts_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bitcnt_q    <= bitcnt_d;
            // Pin registers carry the bit selected by the next state so OUT/TS are flop outputs.
            out_q       <= (state_d == SHIFT) ? shreg_d[bitcnt_d] : 1'b0;
            ts_q        <= (state_d == SHIFT);
        end
    end
endmodule

// File: tb/tb_io_oserdes.sv
// Bench for io_oserdes: WIDTH=8 instance checked cycle by cycle against a bit-queue model,
// plus a WIDTH=2 instance checked against fixed expectations.
module tb_io_oserdes;
    localparam int W = 8;

    logic IOCLK = 1'b0;
    logic RST   = 1'b1;
    int   total = 0;
    int   bad   = 0;

    io_oserdes_if #(.WIDTH(W)) i8 ();
    io_oserdes_if #(.WIDTH(2)) i2 ();

    io_oserdes #(.WIDTH(W)) dut8 (.IOCLK(IOCLK), .RST(RST), .s(i8.slave));
    io_oserdes #(.WIDTH(2)) dut2 (.IOCLK(IOCLK), .RST(RST), .s(i2.slave));

    always #5 IOCLK = ~IOCLK;

    // Model: every bit still to appear on the pin, in pin order. The block holds
    // at most two words, so it can take a new one only while <= W bits are pending.
    bit mq[$];
    bit last_xfer;

    function automatic logic [3:0] expv();
        logic b;
        b = (mq.size() > 0) ? mq[0] : 1'b0;
        return {b, mq.size() > 0, mq.size() > 0, !RST && (mq.size() <= W)};
    endfunction

    task automatic tick();
        bit x;
        x = i8.DVALID && !RST && (mq.size() <= W);
        @(posedge IOCLK);
        if (RST) mq.delete();
        else begin
            if (mq.size() > 0) void'(mq.pop_front());
            if (x) for (int i = 0; i < W; i++) mq.push_back(i8.DIN[i]);
        end
        last_xfer = x;
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; i8.DVALID = 1'b0; i8.DIN = '0; i2.DVALID = 1'b0; i2.DIN = '0;
        #1;
        total++;
        if (i8.DREADY !== 1'b0) begin bad++; $display("FAIL reset_dready_during got %b exp 0", i8.DREADY); end
        tick(); tick();
        total++;
        if ({i8.OUT, i8.TS, i8.BUSY, i8.DREADY} !== 4'b0000) begin
            bad++; $display("FAIL reset_state got %b exp 0000", {i8.OUT, i8.TS, i8.BUSY, i8.DREADY});
        end
        RST = 1'b0; #1;
        total++;
        if (i8.DREADY !== 1'b1 || i2.DREADY !== 1'b1) begin
            bad++; $display("FAIL reset_release got %b%b exp 11", i8.DREADY, i2.DREADY);
        end
    endtask

    task automatic test_single();
        int ts_cnt = 0;
        logic [7:0] got = '0;
        i8.DVALID = 1'b1; i8.DIN = 8'hA5;
        tick();
        i8.DVALID = 1'b0; i8.DIN = 8'h00;
        for (int c = 1; c <= 12; c++) begin
            total++;
            if ({i8.OUT, i8.TS, i8.BUSY, i8.DREADY} !== expv()) begin
                bad++; $display("FAIL single cyc%0d got %b exp %b", c, {i8.OUT, i8.TS, i8.BUSY, i8.DREADY}, expv());
            end
            if (i8.TS === 1'b1) begin got[ts_cnt[2:0]] = i8.OUT; ts_cnt++; end
            tick();
        end
        total++;
        if (ts_cnt != 8 || got !== 8'hA5) begin
            bad++; $display("FAIL single_burst ts=%0d bits=%h exp ts=8 bits=a5", ts_cnt, got);
        end
    endtask

    task automatic test_back_to_back();
        int ts_cnt = 0, falls = 0;
        logic prev_ts = 1'b0;
        logic [15:0] got = '0;
        for (int e = 0; e < 24; e++) begin
            i8.DVALID = (e == 0 || e == 3);
            i8.DIN = (e == 0) ? 8'h0F : 8'hF0;
            tick();
            i8.DVALID = 1'b0;
            total++;
            if ({i8.OUT, i8.TS, i8.BUSY, i8.DREADY} !== expv()) begin
                bad++; $display("FAIL b2b cyc%0d got %b exp %b", e + 1, {i8.OUT, i8.TS, i8.BUSY, i8.DREADY}, expv());
            end
            if (e + 1 >= 4 && e + 1 <= 8) begin
                total++;
                if (i8.DREADY !== 1'b0) begin bad++; $display("FAIL b2b_dready cyc%0d got 1 exp 0", e + 1); end
            end
            if (prev_ts && !i8.TS) falls++;
            if (i8.TS === 1'b1) begin got[ts_cnt[3:0]] = i8.OUT; ts_cnt++; end
            prev_ts = i8.TS;
        end
        total++;
        if (ts_cnt != 16 || falls != 1 || got !== 16'hF00F) begin
            bad++; $display("FAIL b2b_burst ts=%0d falls=%0d bits=%h exp 16/1/f00f", ts_cnt, falls, got);
        end
    endtask

    task automatic test_three();
        logic [7:0] words [3] = '{8'h01, 8'h02, 8'h03};
        int idx = 0, ts_cnt = 0, falls = 0;
        logic prev_ts = 1'b0;
        logic [23:0] got = '0;
        for (int c = 0; c < 34; c++) begin
            i8.DVALID = (idx < 3);
            i8.DIN = (idx < 3) ? words[idx] : 8'h00;
            tick();
            if (last_xfer) idx++;
            total++;
            if ({i8.OUT, i8.TS, i8.BUSY, i8.DREADY} !== expv()) begin
                bad++; $display("FAIL three cyc%0d got %b exp %b", c + 1, {i8.OUT, i8.TS, i8.BUSY, i8.DREADY}, expv());
            end
            if (prev_ts && !i8.TS) falls++;
            if (i8.TS === 1'b1 && ts_cnt < 24) got[ts_cnt] = i8.OUT;
            if (i8.TS === 1'b1) ts_cnt++;
            prev_ts = i8.TS;
        end
        i8.DVALID = 1'b0;
        total++;
        if (ts_cnt != 24 || falls != 1 || got !== 24'h030201 || idx != 3) begin
            bad++; $display("FAIL three_burst ts=%0d falls=%0d bits=%h words=%0d exp 24/1/030201/3", ts_cnt, falls, got, idx);
        end
    endtask

    task automatic test_last_edge();
        int ts_cnt = 0, falls = 0;
        logic prev_ts = 1'b0;
        for (int e = 0; e < 20; e++) begin
            i8.DVALID = (e == 0 || e == 8);
            i8.DIN = (e == 0) ? 8'h96 : 8'h3C;
            if (e == 8) begin
                total++;
                if (i8.DREADY !== 1'b1) begin bad++; $display("FAIL last_edge_ready got %b exp 1", i8.DREADY); end
            end
            tick();
            i8.DVALID = 1'b0;
            total++;
            if ({i8.OUT, i8.TS, i8.BUSY, i8.DREADY} !== expv()) begin
                bad++; $display("FAIL last_edge cyc%0d got %b exp %b", e + 1, {i8.OUT, i8.TS, i8.BUSY, i8.DREADY}, expv());
            end
            if (prev_ts && !i8.TS) falls++;
            if (i8.TS === 1'b1) ts_cnt++;
            prev_ts = i8.TS;
        end
        total++;
        if (ts_cnt != 16 || falls != 1) begin
            bad++; $display("FAIL last_edge_gap ts=%0d falls=%0d exp 16/1", ts_cnt, falls);
        end
    endtask

    task automatic test_reset_mid();
        int ts_cnt = 0;
        for (int e = 0; e < 4; e++) begin
            i8.DVALID = (e <= 1);
            i8.DIN = (e == 0) ? 8'h3C : 8'hC3;
            tick();
            i8.DVALID = 1'b0;
        end
        total++;
        if (i8.DREADY !== 1'b0 || i8.TS !== 1'b1) begin
            bad++; $display("FAIL rmid_prep ready=%b ts=%b exp 0/1", i8.DREADY, i8.TS);
        end
        RST = 1'b1; #1;
        total++;
        if (i8.DREADY !== 1'b0) begin bad++; $display("FAIL rmid_ready_in_rst got %b exp 0", i8.DREADY); end
        tick();
        total++;
        if ({i8.OUT, i8.TS, i8.BUSY} !== 3'b000) begin
            bad++; $display("FAIL rmid_after got %b exp 000", {i8.OUT, i8.TS, i8.BUSY});
        end
        RST = 1'b0; #1;
        total++;
        if (i8.DREADY !== 1'b1) begin bad++; $display("FAIL rmid_ready_after got %b exp 1", i8.DREADY); end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (i8.TS === 1'b1) ts_cnt++;
        end
        total++;
        if (ts_cnt != 0) begin bad++; $display("FAIL rmid_retransmit ts_cycles=%0d exp 0", ts_cnt); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            i8.DVALID = ($urandom_range(0, 9) < 6);
            i8.DIN = 8'($urandom);
            RST = ($urandom_range(0, 99) == 0);
            tick();
            total++;
            if ({i8.OUT, i8.TS, i8.BUSY, i8.DREADY} !== expv()) begin
                bad++; $display("FAIL random cyc%0d got %b exp %b", c, {i8.OUT, i8.TS, i8.BUSY, i8.DREADY}, expv());
            end
        end
        RST = 1'b0; i8.DVALID = 1'b0;
        for (int c = 0; c < 20; c++) tick();
    endtask

    task automatic test_width2();
        logic [1:0] exp_seq [4] = '{2'b01, 2'b11, 2'b00, 2'b00};
        i2.DVALID = 1'b1; i2.DIN = 2'b10;
        tick();
        i2.DVALID = 1'b0; i2.DIN = 2'b11;
        for (int c = 0; c < 4; c++) begin
            total++;
            if ({i2.OUT, i2.TS} !== exp_seq[c]) begin
                bad++; $display("FAIL width2 cyc%0d got out/ts=%b exp %b", c + 1, {i2.OUT, i2.TS}, exp_seq[c]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_three();
        test_last_edge();
        test_reset_mid();
        test_random();
        test_width2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/io_oserdes.md
# io_oserdes

Parallel-to-serial output stage that sits directly upstream of an IO block and drives its OUT and TS inputs. It accepts WIDTH-bit words from fabric logic over a valid/ready handshake and shifts them LSB-first onto OUT, one bit per IOCLK cycle. TS is asserted only while a bit is being driven, so the pin is released to high-Z between bursts when the IO block's tristate mux is in TS-controlled mode. A one-word holding buffer makes back-to-back words gapless on the pin.

## Interface

Parameters:
- WIDTH, default 8, bits per word; legal range 2..32.

Ports:
- IOCLK, input, 1: sole clock; all state updates on rising edge.
- RST, input, 1: synchronous, active-high reset.
- DIN, input, WIDTH: parallel word, bit 0 transmitted first.
- DVALID, input, 1: DIN holds a valid word.
- DREADY, output, 1: the block can accept a word; a transfer occurs on a rising edge with DVALID=1 and DREADY=1.
- OUT, output, 1: serial data to IO block OUT; registered.
- TS, output, 1: drive enable to IO block TS (1 = drive pin, 0 = release); registered.
- BUSY, output, 1: high while in SHIFT state.

## Operation

- Internal registers: shift register SHREG[WIDTH], bit counter BITCNT (0..WIDTH-1), holding register HOLD[WIDTH] with flag HOLD_FULL, state register STATE ∈ {IDLE, SHIFT}.
- DREADY = !HOLD_FULL && !RST; combinational from registers and RST only, never from DVALID.
- IDLE:
  - TS=0, OUT=0, BUSY=0.
  - On a transfer: SHREG←DIN, BITCNT←0, STATE←SHIFT. HOLD stays empty.
- SHIFT:
  - OUT=SHREG[BITCNT] (registered form), TS=1, BUSY=1.
  - Not last bit (BITCNT<WIDTH-1): BITCNT increments. A transfer this edge loads HOLD and sets HOLD_FULL.
  - Last-bit edge (BITCNT==WIDTH-1), next word source in priority order:
    - HOLD_FULL=1: SHREG←HOLD, clear HOLD_FULL, BITCNT←0, stay in SHIFT. DREADY was 0, so no transfer can collide.
    - A transfer this edge: SHREG←DIN directly, BITCNT←0, stay in SHIFT. HOLD stays empty.
    - Otherwise: STATE←IDLE.
- DIN is sampled only on transfer edges; later changes to DIN have no effect.
- The block holds at most two words, one in SHREG and one in HOLD. A third word is back-pressured.

## Timing

- Reset (RST=1 at an edge): STATE=IDLE, BITCNT=0, HOLD_FULL=0, SHREG=0, HOLD=0. After that edge OUT=0, TS=0, BUSY=0. DREADY=0 combinationally while RST=1 and 1 after release.
- Reset mid-word: the partially shifted word and HOLD are discarded. TS falls to 0 on the cycle after the reset edge, and nothing is retransmitted.
- Latency: a transfer at edge N puts DIN[0] on OUT with TS=1 during cycle N+1. Bit k appears in cycle N+1+k.
- Burst: a single word gives TS high for exactly WIDTH cycles. TS falls after the last bit unless a next word is available at the last-bit edge.
- Gapless rule: a word accepted at or before the last-bit edge of the current word starts in the very next cycle, with no TS low gap.
- DREADY falls the cycle after HOLD is filled. It rises the cycle after HOLD moves into SHREG.
- Simultaneous RST and DVALID: reset wins and no transfer occurs, since DREADY=0.

## Test plan

- Reset, then one word with WIDTH=8 and DIN=8'hA5 at edge 0. Required: OUT = 1,0,1,0,0,1,0,1 in cycles 1–8, TS=1 in cycles 1–8, TS=0 and BUSY=0 from cycle 9.
- Words 8'h0F then 8'hF0, with the second transferred at edge 3. Required: 16 consecutive TS=1 cycles, OUT = 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1, DREADY low from cycle 4 through cycle 8.
- DVALID held high with three words 8'h01, 8'h02, 8'h03. Required: the third transfer waits until DREADY=1 after HOLD drains. Output is 24 gapless bits with TS=1 throughout, and no word is lost or duplicated.
- Second word transferred exactly at the last-bit edge with HOLD empty. Required: it loads directly into SHREG, there is no TS gap, and DREADY stays 1.
- Assert RST in cycle 4 of a word while HOLD is full. Required: TS=0, OUT=0, BUSY=0 in the next cycle; DREADY=0 during RST and 1 afterward; the held word is never transmitted.
- WIDTH=2, DIN=2'b10, single transfer. Required: OUT = 0,1 with TS=1 for exactly 2 cycles.
